zbreak: RTL



---
 rtl/zbreak_pkg.sv | 47 ++++
 rtl/zbreak_cmp.sv | 44 ++++
 rtl/zbreak.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/zbreak_pkg.sv
// Shared definitions for the Z80 opcode-fetch breakpoint unit: config
// register map, FSM encoding and the M1-fetch edge-detect convention that the
// NMI generator uses as well.
package zbreak_pkg;

  // Config register selects.
  localparam logic [3:0] BPSEL_ADDR0 = 4'd0;
  localparam logic [3:0] BPSEL_ADDR1 = 4'd1;
  localparam logic [3:0] BPSEL_ADDR2 = 4'd2;
  localparam logic [3:0] BPSEL_ADDR3 = 4'd3;
  localparam logic [3:0] BPSEL_ADDR4 = 4'd4;
  localparam logic [3:0] BPSEL_ADDR5 = 4'd5;
  localparam logic [3:0] BPSEL_ADDR6 = 4'd6;
  localparam logic [3:0] BPSEL_ADDR7 = 4'd7;
  localparam logic [3:0] BPSEL_EN    = 4'd8;
  localparam logic [3:0] BPSEL_PASS  = 4'd9;
  localparam logic [3:0] BPSEL_STAT  = 4'd10;

  // Breakpoint pulse FSM.
  typedef enum logic [1:0] {
    BP_IDLE  = 2'd0,
    BP_PULSE = 2'd1,
    BP_HOLD  = 2'd2
  } bp_state_e;

  // M1 fetch convention: m1_n is sampled on zpos, mreq_n on zneg; the CPU is
  // in an opcode fetch while both sampled values are low.
  function automatic logic m1_fetch(input logic m1_n_s, input logic mreq_n_s);
    return ~m1_n_s & ~mreq_n_s;
  endfunction

  // A fetch starts on the fclk where was_m1 rises against its previous value.
  function automatic logic fetch_edge(input logic was_m1_now, input logic was_m1_prev);
    return was_m1_now & ~was_m1_prev;
  endfunction

  // Index of the lowest set bit (0 when none is set).
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/zbreak_cmp.sv
// One breakpoint comparator: a 16-bit address register written a byte at a
// time through the config bus, and a match flag gated by its enable bit.
module zbreak_cmp import zbreak_pkg::*; #(
  parameter int unsigned IDX = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [7:0]  wdata_i,
  input  logic        en_i,
  input  logic [15:0] a_i,
  output logic [15:0] addr_o,
  output logic        match_o
);

  localparam logic [3:0] SEL_LO = BPSEL_ADDR0 + 4'(2 * IDX);
  localparam logic [3:0] SEL_HI = SEL_LO + 4'd1;

  logic [15:0] addr_q, addr_d;

  // Byte-lane update of the breakpoint address.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
    addr_d = addr_q;
    if (we_i && (sel_i == SEL_LO)) addr_d[7:0]  = wdata_i;
    if (we_i && (sel_i == SEL_HI)) addr_d[15:8] = wdata_i;
  end

  // Address register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the address is a plain register, not RAM, and is reset so readback returns 0 after reset.
    if (!rst_n) begin
      // NOTE: sequential state is always updated with non-blocking assignments.
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o  = addr_q;
  assign match_o = en_i & (a_i == addr_q);

endmodule

// File: rtl/zbreak.sv
// Z80 opcode-fetch breakpoint unit. Detects M1 fetches, compares the fetch
// address against NUM_BP programmable breakpoints and, subject to the pass
// counter and in_nmi, emits a PULSE_W-cycle imm_nmi pulse to the NMI generator.
module zbreak import zbreak_pkg::*; #(
  parameter int unsigned NUM_BP  = 4,
  parameter int unsigned PULSE_W = 4
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              zpos,
  input  logic              zneg,
  input  logic [15:0]       a,
  input  logic              m1_n,
  input  logic              mreq_n,
  input  logic              in_nmi,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_sel,
  input  logic [7:0]        cfg_wdata,
  output logic [7:0]        cfg_rdata,
  output logic              imm_nmi,
  output logic [NUM_BP-1:0] bp_hit,
  output logic [1:0]        hit_idx
);

  // Fetch detection.
  logic m1_s_q, m1_s_d, mreq_s_q, mreq_s_d, was_m1_q;
  logic was_m1, fetch_start;

  // Config/status state.
  logic [NUM_BP-1:0] en_q, en_d;
  logic [7:0]        pass_q, pass_d;
  logic [NUM_BP-1:0] hit_q, hit_d;
  logic [1:0]        hidx_q, hidx_d;
  logic [7:0]        rdata_q, rdata_d;

  // Pulse FSM.
  bp_state_e state_q, state_d;
  logic [3:0] pcnt_q, pcnt_d;

  // Comparator outputs, padded to the fixed 4-entry register map.
  logic [15:0] addr_all [4];
  logic [3:0]  match4;
  logic        any_match, fire;

  for (genvar n = 0; n < 4; n++) begin : g_bp
    if (n < NUM_BP) begin : g_cmp
      zbreak_cmp #(.IDX(n)) u_cmp (
        .clk     (fclk),
        .rst_n   (rst_n),
        .we_i    (cfg_we),
        .sel_i   (cfg_sel),
        .wdata_i (cfg_wdata),
        .en_i    (en_q[n]),
        .a_i     (a),
        .addr_o  (addr_all[n]),
        .match_o (match4[n])
      );
    end else begin : g_none
      assign addr_all[n] = '0;
      assign match4[n]   = 1'b0;
    end
  end

  assign was_m1      = m1_fetch(m1_s_q, mreq_s_q);
  assign fetch_start = fetch_edge(was_m1, was_m1_q);
  assign any_match   = |match4;
  assign fire        = fetch_start & any_match & (pass_q == '0) & ~in_nmi &
                       (state_q == BP_IDLE);

  // Sample M1 on the Z80 rising edge and MREQ on the falling edge.
  always_comb begin
    m1_s_d   = m1_s_q;
    mreq_s_d = mreq_s_q;
    if (zpos) m1_s_d   = m1_n;
    if (zneg) mreq_s_d = mreq_n;
  end

  // Enable mask and pass counter; a counter write beats a same-cycle decrement.
  always_comb begin
    en_d   = en_q;
    pass_d = pass_q;
    if (cfg_we && (cfg_sel == BPSEL_EN)) en_d = cfg_wdata[NUM_BP-1:0];
    if (fetch_start && any_match && (pass_q != '0)) pass_d = pass_q - 8'd1;
    if (cfg_we && (cfg_sel == BPSEL_PASS)) pass_d = cfg_wdata;
  end

  // Sticky hit status: a new fire sets bits that a same-cycle clear cannot remove.
  always_comb begin
    hit_d  = hit_q;
    hidx_d = hidx_q;
    if (cfg_we && (cfg_sel == BPSEL_STAT)) hit_d = hit_q & ~cfg_wdata[NUM_BP-1:0];
    if (fire) begin
      hit_d  = hit_d | match4[NUM_BP-1:0];
      hidx_d = lowest_set(match4);
    end
  end

  // Pulse FSM: fixed-width pulse, then hold until the current fetch ends.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      BP_IDLE: begin
        if (fire) begin
          state_d = BP_PULSE;
          pcnt_d  = 4'(PULSE_W - 1);
        end
      end
      BP_PULSE: begin
        if (pcnt_q == '0) state_d = BP_HOLD;
        else              pcnt_d  = pcnt_q - 4'd1;
      end
      BP_HOLD: begin
        if (!was_m1) state_d = BP_IDLE;
      end
      default: state_d = BP_IDLE;
    endcase
  end

  // Readback mux for the register addressed by cfg_sel.
  always_comb begin
    logic [3:0] hit4;
    logic [3:0] en4;
    hit4              = '0;
    en4               = '0;
    hit4[NUM_BP-1:0]  = hit_q;
    en4[NUM_BP-1:0]   = en_q;
    rdata_d           = '0;
    case (cfg_sel)
      BPSEL_ADDR0, BPSEL_ADDR1, BPSEL_ADDR2, BPSEL_ADDR3,
      BPSEL_ADDR4, BPSEL_ADDR5, BPSEL_ADDR6, BPSEL_ADDR7:
        rdata_d = cfg_sel[0] ? addr_all[cfg_sel[2:1]][15:8] : addr_all[cfg_sel[2:1]][7:0];
      BPSEL_EN:   rdata_d = {4'b0000, en4};
      BPSEL_PASS: rdata_d = pass_q;
      BPSEL_STAT: rdata_d = {hidx_q, 2'b00, hit4};
      default:    rdata_d = '0;
    endcase
  end

  // All top-level state, synchronously reset.
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      m1_s_q   <= 1'b1;
      mreq_s_q <= 1'b1;
      was_m1_q <= 1'b0;
      en_q     <= '0;
      pass_q   <= '0;
      hit_q    <= '0;
      hidx_q   <= '0;
      rdata_q  <= '0;
      state_q  <= BP_IDLE;
      pcnt_q   <= '0;
    end else begin
      m1_s_q   <= m1_s_d;
      mreq_s_q <= mreq_s_d;
      was_m1_q <= was_m1;
      en_q     <= en_d;
      pass_q   <= pass_d;
      hit_q    <= hit_d;
      hidx_q   <= hidx_d;
      rdata_q  <= rdata_d;
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign cfg_rdata = rdata_q;
  assign imm_nmi   = (state_q == BP_PULSE);
  assign bp_hit    = hit_q;
  assign hit_idx   = hidx_q;

endmodule
